// File: rtl/rapid_pkg.sv
// ---------------------------------------------------------------------------
// rapid_pkg
//   Shared core-wide constants and types used by the writeback arbiter.
//   Contents:
//     XLEN        datapath width (32)
//     REG_ADDR_W  architectural register index width (5)
//     NUM_REGS    number of architectural registers (32)
//     MAX_WB_REQ  upper bound on writeback requesters (8)
//     wb_req_s    one writeback request: destination register + result data
//     ptr_width() width of an index into an n-entry vector (at least 1 bit)
// ---------------------------------------------------------------------------
package rapid_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int MAX_WB_REQ = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_s;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Writeback request bundle between the execute/memory units and the
//   register-file writeback arbiter.
//   Signals:
//     req_valid[k]  requester k has a result to write
//     req[k]        destination register and data of requester k
//     req_ready[k]  requester k is accepted this cycle (combinational)
//   Modports:
//     master  requester side (drives valid/req, observes ready)
//     slave   arbiter side   (observes valid/req, drives ready)
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import rapid_pkg::*;

  logic    [NUM_REQ-1:0] req_valid;
  wb_req_s [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] req_ready;

  modport master (output req_valid, output req, input  req_ready);
  modport slave  (input  req_valid, input  req, output req_ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker: grants the first asserted request at
//   or after i_ptr, wrapping past N-1 back to 0.
//   Ports:
//     i_req          request vector
//     i_ptr          highest-priority index this cycle (must be < N)
//     o_grant        one-hot grant (all zero when no request)
//     o_grant_idx    binary index of the granted request
//     o_grant_valid  some request was granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import rapid_pkg::*;
#(
  parameter  int N     = 3,
  localparam int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [PTR_W:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that skips
    // an assignment would otherwise infer a latch.
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    idx           = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!o_grant_valid && i_req[idx[PTR_W-1:0]]) begin
        o_grant_valid              = 1'b1;
        o_grant_idx                = idx[PTR_W-1:0];
        o_grant[idx[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   sources. Requests to x0 are drained immediately without a write; the
//   rest are arbitrated round-robin and the winner is registered onto
//   o_rd/o_rd_data one cycle later (o_rd == 0 means no write).
//   Optional feature macro: RAPID_WB_SCOREBOARD_EN builds a per-register
//   busy scoreboard; without it the busy outputs are tied low.
//   Ports:
//     i_clk, i_reset        clock, asynchronous active-high reset
//     wb (slave)            requester valid / {rd,data} / ready bundle
//     o_rd, o_rd_data       register-file write port (registered)
//     i_issue_valid/_rd     issued instruction that will write i_issue_rd
//     i_rs1, i_rs2          source registers being decoded
//     o_rs1_busy/_rs2_busy  source has an outstanding write
//   NUM_REQ must be in 2..MAX_WB_REQ.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import rapid_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  regfile_wb_arbiter_if.slave   wb,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_rd_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] drain;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [PTR_W-1:0]   rr_ptr;

  // x0 results never reach the write port, so they are accepted at once
  // and kept out of arbitration.
  always_comb begin
    drain   = '0;
    arb_req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      drain[k]   = wb.req_valid[k] && (wb.req[k].rd == '0);
      arb_req[k] = wb.req_valid[k] && (wb.req[k].rd != '0);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .i_req         (arb_req),
    .i_ptr         (rr_ptr),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_grant_valid (grant_valid)
  );

  // Held in reset, nothing is accepted so pending requests are dropped.
  assign wb.req_ready = i_reset ? '0 : (drain | grant);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_ptr    <= '0;
      o_rd      <= '0;
      o_rd_data <= '0;
    end else if (grant_valid) begin
      o_rd      <= wb.req[grant_idx].rd;
      o_rd_data <= wb.req[grant_idx].data;
      rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end else begin
      // Data is left as-is on idle cycles; o_rd == 0 already means no write.
      o_rd <= '0;
    end
  end

`ifdef RAPID_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear for the landing write first, then set for a new issue, so a
  // same-register set and clear in one cycle leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (o_rd != '0) busy_nxt[o_rd] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the busy vector is control state, not a storage array, so it is
  // reset; stale busy bits after reset would stall decode forever.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) busy <= '0;
    else         busy <= busy_nxt;
  end

  // The regfile bypasses the write landing this cycle, so that source is
  // not reported busy.
  assign o_rs1_busy = busy[i_rs1] && (o_rd != i_rs1);
  assign o_rs2_busy = busy[i_rs2] && (o_rd != i_rs2);
`else
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{i_issue_valid, i_issue_rd, i_rs1, i_rs2};
  assign o_rs1_busy = 1'b0;
  assign o_rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter with NUM_REQ = 3. Inputs change
//   1 time unit after a rising edge; outputs are sampled 1 unit later.
//   A small register-file model captures o_rd/o_rd_data on each edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  import rapid_pkg::*;

  localparam int NUM_REQ = 3;

  logic                  i_clk = 1'b0;
  logic                  i_reset = 1'b0;
  logic [REG_ADDR_W-1:0] o_rd;
  logic [XLEN-1:0]       o_rd_data;
  logic                  i_issue_valid;
  logic [REG_ADDR_W-1:0] i_issue_rd;
  logic [REG_ADDR_W-1:0] i_rs1;
  logic [REG_ADDR_W-1:0] i_rs2;
  logic                  o_rs1_busy;
  logic                  o_rs2_busy;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] rf [NUM_REGS];

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ)) wb_if ();

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .wb            (wb_if.slave),
    .o_rd          (o_rd),
    .o_rd_data     (o_rd_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy)
  );

  always #5 i_clk = ~i_clk;

  // Register-file model: x0 is never written.
  always @(posedge i_clk) begin
    if (o_rd != '0) rf[o_rd] <= o_rd_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] k, input logic v,
                         input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    wb_if.req_valid[k] = v;
    wb_if.req[k].rd    = rd;
    wb_if.req[k].data  = d;
  endtask

  task automatic clr_all();
    wb_if.req_valid = '0;
    wb_if.req       = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) rf[r] = '0;
    clr_all();
    i_issue_valid = 1'b0;
    i_issue_rd    = '0;
    i_rs1         = '0;
    i_rs2         = '0;

    // Reset state, with requests present while reset is held.
    set_req(2'd0, 1'b1, 5'd1, 32'h11);
    set_req(2'd1, 1'b1, 5'd2, 32'h22);
    set_req(2'd2, 1'b1, 5'd3, 32'h33);
    #1 i_reset = 1'b1;
    #1;
    check("rst_rd",      o_rd, 0);
    check("rst_data",    o_rd_data, 0);
    check("rst_ready",   wb_if.req_ready, 0);
    check("rst_busy1",   o_rs1_busy, 0);
    tick();
    check("rst_rd_hold", o_rd, 0);
    check("rst_ready_hold", wb_if.req_ready, 0);
    clr_all();
    i_reset = 1'b0;
    tick();

    // Single request k=1, rd=5.
    set_req(2'd1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("single_ready", wb_if.req_ready, 3'b010);
    tick();
    check("single_rd",   o_rd, 5);
    check("single_data", o_rd_data, 32'hDEADBEEF);
    clr_all();
    #1 check("single_drop_ready", wb_if.req_ready, 3'b000);
    tick();
    check("idle_rd", o_rd, 0);

    // Pointer moved past requester 1, so requester 2 wins next.
    set_req(2'd0, 1'b1, 5'd1, 32'h100);
    set_req(2'd1, 1'b1, 5'd2, 32'h200);
    set_req(2'd2, 1'b1, 5'd3, 32'h300);
    #1 check("ptr_after1_ready", wb_if.req_ready, 3'b100);
    tick();
    check("ptr_after1_rd", o_rd, 3);

    // Asynchronous reset mid-cycle with requests outstanding.
    #2 i_reset = 1'b1;
    #1;
    check("midrst_rd",    o_rd, 0);
    check("midrst_data",  o_rd_data, 0);
    check("midrst_ready", wb_if.req_ready, 0);
    check("midrst_busy2", o_rs2_busy, 0);
    #1 i_reset = 1'b0;

    // All three held valid from rr_ptr = 0: grants 0,1,2,0.
    #1 check("rr_ready0", wb_if.req_ready, 3'b001);
    tick();
    check("rr_rd0",   o_rd, 1);
    check("rr_data0", o_rd_data, 32'h100);
    check("rr_ready1", wb_if.req_ready, 3'b010);
    tick();
    check("rr_rd1",   o_rd, 2);
    check("rr_ready2", wb_if.req_ready, 3'b100);
    tick();
    check("rr_rd2",   o_rd, 3);
    check("rr_data2", o_rd_data, 32'h300);
    check("rr_ready3", wb_if.req_ready, 3'b001);
    tick();
    check("rr_rd3",   o_rd, 1);
    clr_all();

    // x0 drain alongside a real write (rr_ptr = 1).
    set_req(2'd0, 1'b1, 5'd0, 32'hAAAA);
    set_req(2'd1, 1'b1, 5'd7, 32'h7777);
    #1 check("x0_ready", wb_if.req_ready, 3'b011);
    tick();
    check("x0_rd",   o_rd, 7);
    check("x0_data", o_rd_data, 32'h7777);
    clr_all();
    tick();
    check("x0_only_one_write", o_rd, 0);

    // Wrap: rr_ptr = 2 with only 0 and 1 requesting -> 0 first, then 1.
    set_req(2'd0, 1'b1, 5'd4, 32'h44);
    set_req(2'd1, 1'b1, 5'd6, 32'h66);
    #1 check("wrap_ready0", wb_if.req_ready, 3'b001);
    tick();
    check("wrap_rd0", o_rd, 4);
    set_req(2'd0, 1'b0, 5'd0, 32'h0);
    #1 check("wrap_ready1", wb_if.req_ready, 3'b010);
    tick();
    check("wrap_rd1", o_rd, 6);
    clr_all();

    // Same rd from requesters 0 and 2 (rr_ptr = 2): 2 first, 0 lands last.
    set_req(2'd0, 1'b1, 5'd9, 32'hA0A0);
    set_req(2'd2, 1'b1, 5'd9, 32'hB0B0);
    #1 check("same_ready_a", wb_if.req_ready, 3'b100);
    tick();
    check("same_rd_a",   o_rd, 9);
    check("same_data_a", o_rd_data, 32'hB0B0);
    set_req(2'd2, 1'b0, 5'd0, 32'h0);
    #1 check("same_ready_b", wb_if.req_ready, 3'b001);
    tick();
    check("same_rd_b",   o_rd, 9);
    check("same_data_b", o_rd_data, 32'hA0A0);
    clr_all();

    // Idle cycles leave the register file alone.
    tick();
    check("idle2_rd", o_rd, 0);
    check("rf_x9",    rf[9], 32'hA0A0);
    tick();
    check("idle3_rd", o_rd, 0);
    check("rf_x9_hold", rf[9], 32'hA0A0);
    check("rf_x0",    rf[0], 0);

`ifdef RAPID_WB_SCOREBOARD_EN
    // Issue rd=9, then retire it while re-issuing rd=9 (rr_ptr = 1).
    i_rs1 = 5'd9;
    i_rs2 = 5'd3;
    i_issue_valid = 1'b1;
    i_issue_rd    = 5'd9;
    tick();
    i_issue_valid = 1'b0;
    #1;
    check("sb_busy_set",  o_rs1_busy, 1);
    check("sb_other_free", o_rs2_busy, 0);
    tick();
    check("sb_busy_hold", o_rs1_busy, 1);
    set_req(2'd0, 1'b1, 5'd9, 32'h99);
    #1 check("sb_wr_ready", wb_if.req_ready, 3'b001);
    tick();
    clr_all();
    i_issue_valid = 1'b1;
    i_issue_rd    = 5'd9;
    #1;
    check("sb_land_rd",     o_rd, 9);
    check("sb_bypass_free", o_rs1_busy, 0);
    tick();
    i_issue_valid = 1'b0;
    #1;
    check("sb_set_wins", o_rs1_busy, 1);
    set_req(2'd1, 1'b1, 5'd9, 32'h98);
    tick();
    clr_all();
    tick();
    check("sb_cleared", o_rs1_busy, 0);
`else
    // Scoreboard not built: busy outputs stay low whatever is issued.
    i_rs1 = 5'd9;
    i_rs2 = 5'd9;
    i_issue_valid = 1'b1;
    i_issue_rd    = 5'd9;
    tick();
    check("nosb_busy1", o_rs1_busy, 0);
    check("nosb_busy2", o_rs2_busy, 0);
    tick();
    i_issue_valid = 1'b0;
    #1;
    check("nosb_busy1_b", o_rs1_busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
